// File: rtl/twos_to_signmag.sv
// Purpose: stream two's-complement words into sign + magnitude, saturating the most-negative code.
// Latency: two register stages; a word offered in cycle N appears on the outputs in cycle N+2.
// Backpressure: valid/ready, 2-word buffering; in_ready is combinational from out_ready.
module twos_to_signmag #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-2:0] out_mag,
    output logic             out_sat,
    input  logic             clear_count,
    output logic [CNT_W-1:0] sat_count
);

    localparam logic [WIDTH-2:0] MAG_MAX  = '1;
    localparam logic [WIDTH-2:0] MAG_ONE  = {{(WIDTH-2){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Stage s1: sign bit split from the low bits. The low bits of a negation only
    // depend on the low bits of the operand, so the MSB is never needed again.
    logic             s1_valid;
    logic             s1_sign;
    logic [WIDTH-2:0] s1_low;

    logic             s1_load;
    logic             s2_load;
    logic             out_fire;

    logic             mag_sat;
    logic [WIDTH-2:0] mag_val;

    // s2 takes a word when it is empty or is being drained this cycle; s1 is free
    // when empty or when its word moves on to s2 in the same cycle.
    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign s1_load  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Magnitude of the word in s1; the most-negative code has no positive twin and clamps.
    always_comb begin
        mag_sat = s1_sign & (s1_low == '0);
        mag_val = s1_low;
        if (mag_sat) begin
            mag_val = MAG_MAX;
        end else if (s1_sign) begin
            mag_val = ~s1_low + MAG_ONE;
        end
    end

    // Stage s1 register: capture on accept, empty when drained without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_low   <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_sign  <= in_data[WIDTH-1];
            s1_low   <= in_data[WIDTH-2:0];
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage s2 output registers: hold while stalled, keep last values once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_mag   <= '0;
            out_sat   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_sign  <= s1_sign;
            out_mag   <= mag_val;
            out_sat   <= mag_sat;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Saturated-word counter: counts delivered saturated words, sticks at full scale,
    // and a clear request overrides a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (clear_count) begin
            sat_count <= '0;
        end else if (out_fire && out_sat && (sat_count != CNT_MAX)) begin
            sat_count <= sat_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_twos_to_signmag.sv
// Bench for twos_to_signmag: directed scenarios plus randomized traffic.
// Expected results come from an integer-arithmetic reference model and a queue scoreboard.
// A negedge monitor checks every output transfer, stall stability and the saturation count.
module tb_twos_to_signmag;

    localparam int W     = 8;
    localparam int CW    = 16;
    localparam int MAG_W = W - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sign;
    logic [W-2:0]  out_mag;
    logic          out_sat;
    logic          clear_count = 1'b0;
    logic [CW-1:0] sat_count;

    int checks = 0;
    int errors = 0;

    twos_to_signmag #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_mag     (out_mag),
        .out_sat     (out_sat),
        .clear_count (clear_count),
        .sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic             s;
        logic [MAG_W-1:0] m;
        logic             t;
    } res_t;

    // Reference: interpret the word as a signed integer and take its absolute value,
    // clamping when that value does not fit in the magnitude field.
    function automatic res_t ref_model(input logic [W-1:0] d);
        int   v;
        int   a;
        res_t r;
        v = int'($signed(d));
        a = (v < 0) ? -v : v;
        r.s = (v < 0);
        r.t = (a > (1 << MAG_W) - 1);
        r.m = r.t ? MAG_W'((1 << MAG_W) - 1) : MAG_W'(a);
        return r;
    endfunction

    res_t        exp_q[$];
    res_t        e;
    int unsigned cnt_model = 0;
    logic        stall_prev = 1'b0;
    logic [8:0]  held = '0;

    // Monitor: inputs and outputs are stable at the falling edge, so the transfers
    // seen here are exactly the ones the next rising edge performs.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cnt_model  = 0;
            stall_prev = 1'b0;
        end else begin
            check("sat_count", 32'(sat_count), cnt_model);
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'({out_sign, out_mag, out_sat}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_sign", 32'(out_sign), 32'(e.s));
                    check("out_mag", 32'(out_mag), 32'(e.m));
                    check("out_sat", 32'(out_sat), 32'(e.t));
                    if (!clear_count && e.t && cnt_model < (1 << CW) - 1) cnt_model++;
                end
            end
            if (clear_count) cnt_model = 0;
            if (in_valid && in_ready) exp_q.push_back(ref_model(in_data));
            stall_prev = out_valid & ~out_ready;
            held       = {out_sign, out_mag, out_sat};
        end
    end

    // Offer one word (call just after a rising edge); returns just after the accepting edge.
    task automatic send_word(input logic [W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] t3_vals [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    int idx;
    int sent;
    int acc;
    logic pending;

    initial begin
        // Reset state, checked asynchronously before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sat_count", 32'(sat_count), 0);
        check("rst_out_fields", 32'({out_sign, out_mag, out_sat}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1: back-to-back words with latency check.
        out_ready = 1'b1;
        @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h05;
        @(negedge clk);
        check("t1_in_ready", 32'(in_ready), 1);
        check("t1_lat0", 32'(out_valid), 0);
        @(posedge clk); #1; in_data = 8'hFB;
        @(negedge clk);
        check("t1_lat1", 32'(out_valid), 0);
        @(posedge clk); #1; in_data = 8'h00;
        @(negedge clk);
        check("t1_lat2", 32'(out_valid), 1);
        check("t1_w0", 32'({out_sign, out_mag}), 32'h005);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        check("t1_w1", 32'({out_valid, out_sign, out_mag}), 32'h185);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_w2", 32'({out_valid, out_sign, out_mag}), 32'h100);
        repeat (3) @(posedge clk);
        #1;

        // Test 2: most-negative saturates, its neighbour does not.
        send_word(8'h80);
        send_word(8'h81);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t2_sat_count", 32'(sat_count), 1);
        @(posedge clk); #1;

        // Test 3: downstream stalled for the first five cycles.
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 5);
            if (idx < 4) begin
                in_valid = 1'b1;
                in_data  = t3_vals[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 2) check("t3_rdy_drop", 32'(in_ready), 0);
            if (c == 4) begin
                check("t3_accepts", idx, 2);
                check("t3_rdy_low", 32'(in_ready), 0);
                check("t3_held_mag", 32'({out_valid, out_mag}), 32'h090);
            end
            if (in_valid && in_ready) idx++;
        end
        check("t3_all_acc", idx, 4);
        in_valid = 1'b0;

        // Test 4: random traffic on both sides, occasional clears.
        sent    = 0;
        pending = 1'b0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            @(posedge clk); #1;
            out_ready   = ($urandom_range(0, 3) != 0);
            clear_count = ($urandom_range(0, 63) == 0);
            if (!pending) begin
                if ($urandom_range(0, 9) < 7) begin
                    pending  = 1'b1;
                    in_valid = 1'b1;
                    in_data  = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
                end else begin
                    in_valid = 1'b0;
                    in_data  = W'($urandom);
                end
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                pending = 1'b0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; clear_count = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 50 && (exp_q.size() != 0 || out_valid); c++) @(posedge clk);
        #1;
        check("t4_sent", sent, 1000);
        check("t4_drained", exp_q.size(), 0);

        // Test 5: saturate the counter, then clear against a saturated transfer.
        clear_count = 1'b1;
        @(posedge clk); #1; clear_count = 1'b0;
        acc = 0;
        in_valid = 1'b1; in_data = 8'h80;
        for (int c = 0; c < 70000 && acc < 65537; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            if (acc >= 65537) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t5_accepts", acc, 65537);
        check("t5_sat_full", 32'(sat_count), 32'hFFFF);
        @(posedge clk); #1;
        send_word(8'h80);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("t5_out_vld", 32'({out_valid, out_sat}), 32'h3);
        clear_count = 1'b1;
        @(posedge clk); #1; clear_count = 1'b0;
        @(negedge clk);
        check("t5_clear_wins", 32'(sat_count), 0);
        @(posedge clk); #1;

        // Test 6: asynchronous reset with two words in flight.
        send_word(8'h80);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_word(8'h33);
        send_word(8'h44);
        in_valid = 1'b0;
        check("t6_pre_cnt", 32'(sat_count), 1);
        check("t6_pre_full", 32'({out_valid, in_ready}), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_vld", 32'(out_valid), 0);
        check("t6_rst_cnt", 32'(sat_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t6_no_stale", 32'(out_valid), 0);
        end
        check("t6_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
